// File: rtl/jk_pkg.sv
// Shared types for the JK command driver: opcode, FSM state and command layout.
package jk_pkg;

   localparam int JK_WIDTH = 4;
   localparam int JK_DEPTH = 4;
   localparam int JK_RPT_W = 4;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TOG  = 2'b11
   } jk_op_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } jk_state_t;

   // FIFO word layout, MSB first: {op, mask, rpt}
   typedef struct packed {
      jk_op_t                op;
      logic [JK_WIDTH-1:0]   mask;
      logic [JK_RPT_W-1:0]   rpt;
   } jk_cmd_t;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO for the JK driver: synchronous push/pop, async active-low reset.
module jk_cmd_fifo #(
   parameter int DW    = 10,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DW-1:0]              wdata,
   output logic [DW-1:0]              rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // Storage carries no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_driver.sv
// JK command driver: buffers commands, replays them onto j_o/k_o, tracks a shadow bank.
// Optional macro JK_SHADOW_CHECK_EN enables the q_fb vs shadow compare (mismatch_o).
//
// state    | meaning
// ST_IDLE  | no command active; j/k driven to 0, pop head when FIFO non-empty
// ST_ISSUE | replaying current command; cnt counts remaining extra cycles
module jk_cmd_driver
   import jk_pkg::*;
#(
   parameter int WIDTH = JK_WIDTH,
   parameter int DEPTH = JK_DEPTH,
   parameter int RPT_W = JK_RPT_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_op,
   input  logic [WIDTH-1:0]           in_mask,
   input  logic [RPT_W-1:0]           in_rpt,
   output logic [WIDTH-1:0]           j_o,
   output logic [WIDTH-1:0]           k_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [WIDTH-1:0]           q_model_o,
   input  logic [WIDTH-1:0]           q_fb,
   output logic                       mismatch_o
);

   localparam int CW = 2 + WIDTH + RPT_W;

   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic [CW-1:0]     head;
   jk_op_t            head_op;
   logic [WIDTH-1:0]  head_mask;
   logic [RPT_W-1:0]  head_rpt;

   jk_state_t         state;
   logic [RPT_W-1:0]  cnt;
   jk_op_t            cur_op;
   logic [WIDTH-1:0]  cur_mask;

   assign in_ready  = !fifo_full;
   assign head_op   = jk_op_t'(head[CW-1 -: 2]);
   assign head_mask = head[RPT_W +: WIDTH];
   assign head_rpt  = head[RPT_W-1:0];

   // Pop either to start from idle or to chain directly after the last drive cycle.
   assign pop = !fifo_empty && ((state == ST_IDLE) || (cnt == '0));

   jk_cmd_fifo #(
      .DW    (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid),
      .pop   (pop),
      .wdata ({in_op, in_mask, in_rpt}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level_o)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         cur_op   <= JK_HOLD;
         cur_mask <= '0;
         j_o      <= '0;
         k_o      <= '0;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               j_o    <= '0;
               k_o    <= '0;
               busy_o <= 1'b0;
               done_o <= 1'b0;
               if (pop) begin
                  cur_op   <= head_op;
                  cur_mask <= head_mask;
                  cnt      <= head_rpt;
                  state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               j_o    <= cur_mask & {WIDTH{cur_op[1]}};
               k_o    <= cur_mask & {WIDTH{cur_op[0]}};
               busy_o <= 1'b1;
               done_o <= (cnt == '0);
               if (cnt != '0) begin
                  cnt <= cnt - RPT_W'(1);
               end else if (pop) begin
                  cur_op   <= head_op;
                  cur_mask <= head_mask;
                  cnt      <= head_rpt;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Shadow bank follows the registered j/k exactly as the cells do.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_model_o <= '0;
      else        q_model_o <= (j_o & ~q_model_o) | (~k_o & q_model_o);
   end

`ifdef JK_SHADOW_CHECK_EN
   logic [WIDTH-1:0] q_model_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_model_d  <= '0;
         mismatch_o <= 1'b0;
      end else begin
         q_model_d <= q_model_o;
         if (q_fb != q_model_d) mismatch_o <= 1'b1;
      end
   end
`else
   logic unused_q_fb;
   assign unused_q_fb = ^q_fb;
   assign mismatch_o  = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Bench for jk_cmd_driver: directed scenarios plus random traffic against a schedule model.
module tb_jk_cmd_driver;
   import jk_pkg::*;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int R  = 4;
   localparam int N  = 4096;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    in_op = 2'b00;
   logic [W-1:0]  in_mask = '0;
   logic [R-1:0]  in_rpt = '0;
   logic [W-1:0]  j_o, k_o, q_model_o;
   logic [W-1:0]  q_fb = '0;
   logic          busy_o, done_o, mismatch_o;
   logic [2:0]    level_o;

   always #5 clk = ~clk;

   jk_cmd_driver #(.WIDTH(W), .DEPTH(D), .RPT_W(R)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_mask    (in_mask),
      .in_rpt     (in_rpt),
      .j_o        (j_o),
      .k_o        (k_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .level_o    (level_o),
      .q_model_o  (q_model_o),
      .q_fb       (q_fb),
      .mismatch_o (mismatch_o)
   );

   int total = 0;
   int bad   = 0;

   // Model: per-cycle schedule of what each command drives, indexed by edge number.
   logic [1:0]    eop   [N];
   logic [W-1:0]  emask [N];
   bit            ebusy [N];
   bit            edone [N];
   int            npop  [N];
   int            t;
   int            lvl;
   int            last_end;
   logic [W-1:0]  eq;
   bit            emis;
   bit            flip_now;
   bit            flip_next;
   bit            last_acc;
   bit            chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         eop[i] = 2'b00; emask[i] = '0; ebusy[i] = 1'b0; edone[i] = 1'b0; npop[i] = 0;
      end
      t = 0; lvl = 0; last_end = -10; eq = '0; emis = 1'b0;
      flip_now = 1'b0; flip_next = 1'b0;
   endtask

   task automatic model_edge();
      int s, e;
      logic [W-1:0] qprev;
      t++;
      last_acc = in_valid && (lvl < D);
      if (last_acc) begin
         s = (t + 2 > last_end + 1) ? t + 2 : last_end + 1;
         e = s + int'(in_rpt);
         for (int c = s; c <= e; c++) begin
            eop[c] = in_op; emask[c] = in_mask; ebusy[c] = 1'b1;
         end
         edone[e] = 1'b1;
         npop[s-1]++;
         last_end = e;
      end
      lvl = lvl + (last_acc ? 1 : 0) - npop[t];
      if (flip_now) emis = 1'b1;
      qprev = eq;
      case (eop[t-1])
         2'b01:   eq = eq & ~emask[t-1];
         2'b10:   eq = eq | emask[t-1];
         2'b11:   eq = eq ^ emask[t-1];
         default: eq = eq;
      endcase
`ifdef JK_SHADOW_CHECK_EN
      q_fb = flip_next ? (qprev ^ 4'b0100) : qprev;
      flip_now = flip_next;
      flip_next = 1'b0;
`else
      q_fb = W'($urandom);
`endif
   endtask

   task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] m, input logic [R-1:0] r);
      in_valid = v; in_op = op; in_mask = m; in_rpt = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, '0);
   endtask

   task automatic do_reset();
      chk_en = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; q_fb = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      #1;
      check("rst_j",     32'(j_o), 32'(0));
      check("rst_level", 32'(level_o), 32'(0));
      check("rst_ready", 32'(in_ready), 32'(1));
      check("rst_q",     32'(q_model_o), 32'(0));
      check("rst_busy",  32'(busy_o), 32'(0));
      check("rst_mis",   32'(mismatch_o), 32'(0));
      chk_en = 1'b1;
   endtask

   // Single compare process: every post-edge output against the model schedule.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("j",     32'(j_o), 32'(emask[t] & {W{eop[t][1]}}));
         check("k",     32'(k_o), 32'(emask[t] & {W{eop[t][0]}}));
         check("busy",  32'(busy_o), 32'(ebusy[t]));
         check("done",  32'(done_o), 32'(edone[t]));
         check("level", 32'(level_o), 32'(lvl));
         check("ready", 32'(in_ready), 32'(lvl < D));
         check("q",     32'(q_model_o), 32'(eq));
         check("mis",   32'(mismatch_o), 32'(emis));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog t=%0d got=timeout want=finish", t);
      $fatal(1, "watchdog");
   end

   initial begin
      bit got5;
      do_reset();

      // Single SET, mask 0101, rpt 0: accepted at edge 1, drives at edge 3 only.
      step(1'b1, JK_SET, 4'b0101, 4'd0);
      check("acc1", 32'(last_acc), 32'(1));
      idle(2);
      check("set_j",    32'(j_o), 32'h5);
      check("set_k",    32'(k_o), 32'h0);
      check("set_done", 32'(done_o), 32'(1));
      idle(1);
      check("set_q",    32'(q_model_o), 32'h5);
      check("set_j0",   32'(j_o), 32'h0);

      // TOG all bits for 3 cycles (edges 7..9): q 1010, 0101, 1010.
      step(1'b1, JK_TOG, 4'b1111, 4'd2);
      idle(2);
      check("tog_j",     32'(j_o), 32'hf);
      check("tog_done0", 32'(done_o), 32'(0));
      idle(1);
      check("tog_q1",    32'(q_model_o), 32'ha);
      idle(1);
      check("tog_q2",    32'(q_model_o), 32'h5);
      check("tog_done",  32'(done_o), 32'(1));
      idle(1);
      check("tog_q3",    32'(q_model_o), 32'ha);
      check("tog_busy",  32'(busy_o), 32'(0));

      // Long CLR at edge 11 (drives 13..28), then fill the FIFO behind it.
      step(1'b1, JK_CLR, 4'b0011, 4'd15);
      idle(1);
      for (int i = 0; i < 4; i++)
         step(1'b1, 2'($urandom), 4'($urandom), 4'($urandom_range(0, 3)));
      check("full_ready", 32'(in_ready), 32'(0));
      check("full_level", 32'(level_o), 32'(4));
      got5 = 1'b0;
      for (int i = 0; i < 40 && !got5; i++) begin
         step(1'b1, JK_TOG, 4'b1001, 4'd1);
         got5 = last_acc;
      end
      check("acc5",   32'(got5), 32'(1));
      check("acc5_t", 32'(t), 32'(29));
      idle(80);
      check("drain_level", 32'(level_o), 32'(0));
      check("drain_busy",  32'(busy_o), 32'(0));

      // Random traffic at three offered loads.
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 400; i++) begin
            step(($urandom % 10) < (seg == 0 ? 9 : (seg == 1 ? 5 : 2)),
                 2'($urandom), 4'($urandom),
                 (($urandom % 8) == 0) ? 4'd15 : 4'($urandom_range(0, 3)));
         end
      end
      idle(120);
      check("rand_level", 32'(level_o), 32'(0));

      // Async reset mid-command with cnt=3.
      do_reset();
      step(1'b1, JK_TOG, 4'b1111, 4'd5);
      idle(3);
      check("pre_rst_q", 32'(q_model_o), 32'hf);
      check("pre_rst_j", 32'(j_o), 32'hf);
      chk_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("arst_j",    32'(j_o), 32'h0);
      check("arst_k",    32'(k_o), 32'h0);
      check("arst_busy", 32'(busy_o), 32'(0));
      check("arst_done", 32'(done_o), 32'(0));
      check("arst_q",    32'(q_model_o), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      chk_en = 1'b1;
      #1;
      idle(10);
      check("post_rst_level", 32'(level_o), 32'(0));

`ifdef JK_SHADOW_CHECK_EN
      flip_next = 1'b1;
      idle(3);
      check("mis_set", 32'(mismatch_o), 32'(1));
      idle(5);
      check("mis_sticky", 32'(mismatch_o), 32'(1));
      do_reset();
`endif

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/jk_cmd_driver.md
Name: jk_cmd_driver

Overview:
Upstream command stage for a WIDTH-wide bank of JK flip-flop cells. Accepts JK commands (hold/clear/set/toggle, per-bit mask, repeat count) over a valid/ready handshake and buffers them in a small FIFO. Replays each command onto registered j_o/k_o vectors for a programmable number of cycles. Keeps a shadow model of the expected bank state.

Parameters:
WIDTH, 4, number of JK cells driven (j_o/k_o/mask width)
DEPTH, 4, command FIFO entries (power of two, >=2)
RPT_W, 4, width of repeat field; a command drives for in_rpt+1 cycles

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  command valid
in_ready  output  1  FIFO can accept (= not full)
in_op  input  2  00 HOLD, 01 CLR, 10 SET, 11 TOG (same bit order as {j,k})
in_mask  input  WIDTH  bits the command applies to
in_rpt  input  RPT_W  extra drive cycles
j_o  output  WIDTH  registered J vector to cell bank
k_o  output  WIDTH  registered K vector to cell bank
busy_o  output  1  high while in ISSUE
done_o  output  1  one-cycle pulse on the last drive cycle of a command
level_o  output  $clog2(DEPTH)+1  FIFO occupancy
q_model_o  output  WIDTH  shadow of expected cell-bank state
q_fb  input  WIDTH  actual cell outputs (used only with macro)
mismatch_o  output  1  sticky compare error (macro only, else 0)

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, level_o=0, FSM=IDLE, j_o=k_o=0, busy_o=0, done_o=0, q_model_o=0, mismatch_o=0. Reset mid-command aborts the command; no done_o.
- Push: in_valid&&in_ready at a rising edge writes {op,mask,rpt}. in_ready=(level_o<DEPTH). Push while full is not possible; in_valid held while in_ready=0 is ignored.
- No bypass: a push into an empty FIFO is not visible to the FSM until the next cycle.
- Simultaneous push and pop: both occur; level_o unchanged.
- FSM states:
  - IDLE: j_o=k_o=0. If FIFO is non-empty, pop head, load cnt=rpt, go to ISSUE.
  - ISSUE: j_o=mask&{WIDTH{op[1]}}, k_o=mask&{WIDTH{op[0]}}, busy_o=1.
    - If cnt!=0: cnt--, stay.
    - If cnt==0: done_o=1 this cycle. If the FIFO is non-empty, pop the next command and stay in ISSUE with no bubble cycle; otherwise go to IDLE.
- Latency: command accepted at edge E0 drives j_o/k_o from E2 through E2+rpt (rpt+1 cycles), with an idle, empty FIFO.
- HOLD commands still occupy rpt+1 cycles with j_o=k_o=0 and still pulse done_o.
- Shadow model: q_model_o updates each ISSUE cycle using the JK rule on masked bits only, aligned one cycle after j_o/k_o, i.e. when the bank's q updates.
  - CLR: bit -> 0. SET: bit -> 1. TOG: bit -> inverted.
  - Unmasked bits hold.
- Counter wrap: cnt never underflows. rpt=max drives 2^RPT_W cycles.

Optional Feature:
JK_SHADOW_CHECK_EN
- Defined: each cycle, compare q_fb against q_model_o (delayed one cycle to match cell latency). Any difference sets mismatch_o. mismatch_o clears only on reset.
- Undefined: q_fb is unused and mismatch_o is tied to 0.

Decomposition:
- Package jk_pkg:
  - jk_op_t enum (JK_HOLD=2'b00, JK_CLR=2'b01, JK_SET=2'b10, JK_TOG=2'b11)
  - FSM state typedef (ST_IDLE, ST_ISSUE)
  - command struct typedef {op, mask, rpt}, parameterised through localparams
- Sub-module jk_cmd_fifo: synchronous FIFO with async active-low reset, exposing full/empty/level and push/pop.
- The FSM, shadow model and checker live in jk_cmd_driver.

Test Plan:
- Reset then single SET, mask=4'b0101, rpt=0 -> j_o=0101, k_o=0000 for exactly 1 cycle at E2. done_o pulses that cycle. q_model_o=0101 one cycle later.
- TOG, mask=4'b1111, rpt=2 from q_model=0101 -> 3 drive cycles with j_o=k_o=1111. q_model sequence 1010, 0101, 1010. done_o only on the third cycle.
- Push 5 commands back-to-back with DEPTH=4 and no pop possible -> in_ready falls after the 4th accept; the 5th waits. Commands then issue consecutively with no IDLE bubble, and level_o steps back down to 0.
- Push on the same cycle as a pop with level_o=4 at the last ISSUE cycle -> accepted on the following cycle; level_o stays correct; no lost or duplicated command.
- Assert rst_n low mid-ISSUE (cnt=3) -> j_o/k_o/busy_o/q_model_o go to 0 immediately (asynchronously). No done_o. The FIFO is empty after release.
- With JK_SHADOW_CHECK_EN: force q_fb bit 2 opposite to the model for one cycle -> mismatch_o=1 and stays 1 until reset. Without the macro, mismatch_o stays 0.
